// File: rtl/multi_ch_serial_out.sv
// Multi-channel pattern serializer: each channel shifts out a DATA_BIT pattern LSB first,
// with a per-bit rate select. Define MCSO_GRACEFUL_STOP_EN to let STOP finish the current pattern.
module multi_ch_serial_out #(
    parameter int DATA_BIT = 32,
    parameter int CH_NUM   = 4,
    parameter int FAST_DIV = 4,
    parameter int SLOW_DIV = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [1:0]          i_cmd_op,
    input  logic [CH_NUM-1:0]   i_cmd_mask,
    input  logic                i_cmd_mode,
    input  logic [DATA_BIT-1:0] i_output_pattern,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    output logic [CH_NUM-1:0]   o_serial_out,
    output logic [CH_NUM-1:0]   o_bit_tick,
    output logic [CH_NUM-1:0]   o_done_tick,
    output logic [CH_NUM-1:0]   o_busy
);

    localparam int MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int DIV_W   = $clog2(MAX_DIV + 1);
    localparam int CNT_W   = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;

    localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_DIV - 1);
    localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(SLOW_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_BIT - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_START = 2'd1;
    localparam logic [1:0] OP_STOP  = 2'd2;

    // Ready is simply "not in reset", so it is already high at the first edge after release.
    assign o_cmd_ready = ~rst;

    logic cmd_fire;
    assign cmd_fire = i_cmd_valid & o_cmd_ready;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        logic [DATA_BIT-1:0] sh_out_q,   sh_out_d;
        logic [DATA_BIT-1:0] sh_freq_q,  sh_freq_d;
        logic [DATA_BIT-1:0] act_out_q,  act_out_d;
        logic [DATA_BIT-1:0] act_freq_q, act_freq_d;
        logic [0:0]          state_q,    state_d;
        logic                mode_q,     mode_d;
        logic [CNT_W-1:0]    bit_q,      bit_d;
        logic [DIV_W-1:0]    div_q,      div_d;
        logic                ser_q,      ser_d;

        logic             sel;
        logic [DIV_W-1:0] div_last;
        logic             bit_end;
        logic             pat_end;

        always_comb begin
            // NOTE: every variable gets a default first so no path can infer a latch.
            sh_out_d   = sh_out_q;
            sh_freq_d  = sh_freq_q;
            act_out_d  = act_out_q;
            act_freq_d = act_freq_q;
            state_d    = state_q;
            mode_d     = mode_q;
            bit_d      = bit_q;
            div_d      = div_q;
            ser_d      = ser_q;

            sel      = cmd_fire & i_cmd_mask[g];
            div_last = act_freq_q[bit_q] ? FAST_LAST : SLOW_LAST;
            bit_end  = (state_q == ST_RUN) && (div_q == div_last);
            pat_end  = bit_end && (bit_q == BIT_LAST);

            if (state_q == ST_RUN) begin
                if (!bit_end) begin
                    div_d = div_q + 1'b1;
                end else if (!pat_end) begin
                    bit_d = bit_q + 1'b1;
                    div_d = '0;
                    ser_d = act_out_q[bit_q + 1'b1];
                end else if (mode_q) begin
                    // Repeat: pick up whatever the shadows hold now, no idle gap.
                    act_out_d  = sh_out_q;
                    act_freq_d = sh_freq_q;
                    bit_d      = '0;
                    div_d      = '0;
                    ser_d      = sh_out_q[0];
                end else begin
                    state_d = ST_IDLE;
                    bit_d   = '0;
                    div_d   = '0;
                    ser_d   = 1'b0;
                end
            end

            // Commands override the free-running sequence on the accepting edge.
            if (sel) begin
                case (i_cmd_op)
                    OP_LOAD: begin
                        sh_out_d  = i_output_pattern;
                        sh_freq_d = i_freq_pattern;
                    end
                    OP_START: begin
                        act_out_d  = sh_out_q;
                        act_freq_d = sh_freq_q;
                        mode_d     = i_cmd_mode;
                        state_d    = ST_RUN;
                        bit_d      = '0;
                        div_d      = '0;
                        ser_d      = sh_out_q[0];
                    end
                    OP_STOP: begin
                        if (state_q == ST_RUN) begin
`ifdef MCSO_GRACEFUL_STOP_EN
                            mode_d = 1'b0;
`else
                            state_d = ST_IDLE;
                            bit_d   = '0;
                            div_d   = '0;
                            ser_d   = 1'b0;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end

        // NOTE: sequential state uses non-blocking assignments only; pattern
        // registers are reset too because a START right after reset must send zeros.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sh_out_q   <= '0;
                sh_freq_q  <= '0;
                act_out_q  <= '0;
                act_freq_q <= '0;
                state_q    <= ST_IDLE;
                mode_q     <= 1'b0;
                bit_q      <= '0;
                div_q      <= '0;
                ser_q      <= 1'b0;
            end else begin
                sh_out_q   <= sh_out_d;
                sh_freq_q  <= sh_freq_d;
                act_out_q  <= act_out_d;
                act_freq_q <= act_freq_d;
                state_q    <= state_d;
                mode_q     <= mode_d;
                bit_q      <= bit_d;
                div_q      <= div_d;
                ser_q      <= ser_d;
            end
        end

        assign o_serial_out[g] = ser_q;
        assign o_bit_tick[g]   = bit_end;
        assign o_done_tick[g]  = pat_end;
        assign o_busy[g]       = (state_q == ST_RUN);
    end

endmodule

// File: tb/tb_multi_ch_serial_out.sv
// Scoreboard bench for multi_ch_serial_out (DATA_BIT=8, CH_NUM=2, FAST_DIV=2, SLOW_DIV=4);
// per-cycle expectations are queued at START and popped every cycle.
module tb_multi_ch_serial_out;

    localparam int DATA_BIT = 8;
    localparam int CH_NUM   = 2;
    localparam int FAST_DIV = 2;
    localparam int SLOW_DIV = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                i_cmd_valid = 1'b0;
    logic                o_cmd_ready;
    logic [1:0]          i_cmd_op = 2'd3;
    logic [CH_NUM-1:0]   i_cmd_mask = '0;
    logic                i_cmd_mode = 1'b0;
    logic [DATA_BIT-1:0] i_output_pattern = '0;
    logic [DATA_BIT-1:0] i_freq_pattern = '0;
    logic [CH_NUM-1:0]   o_serial_out;
    logic [CH_NUM-1:0]   o_bit_tick;
    logic [CH_NUM-1:0]   o_done_tick;
    logic [CH_NUM-1:0]   o_busy;

    multi_ch_serial_out #(
        .DATA_BIT(DATA_BIT), .CH_NUM(CH_NUM), .FAST_DIV(FAST_DIV), .SLOW_DIV(SLOW_DIV)
    ) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(i_cmd_op), .i_cmd_mask(i_cmd_mask), .i_cmd_mode(i_cmd_mode),
        .i_output_pattern(i_output_pattern), .i_freq_pattern(i_freq_pattern),
        .o_serial_out(o_serial_out), .o_bit_tick(o_bit_tick),
        .o_done_tick(o_done_tick), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic busy;
        logic ser;
        logic tick;
        logic done;
    } exp_t;

    exp_t exp_q [CH_NUM][$];
    logic [DATA_BIT-1:0] sh_out [CH_NUM];
    logic [DATA_BIT-1:0] sh_freq [CH_NUM];

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int tick_cnt = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_pat(input int ch, input logic [DATA_BIT-1:0] out, input logic [DATA_BIT-1:0] freq);
        for (int k = 0; k < DATA_BIT; k++) begin
            int len;
            len = freq[k] ? FAST_DIV : SLOW_DIV;
            for (int c = 0; c < len; c++) begin
                exp_t e;
                e.busy = 1'b1;
                e.ser  = out[k];
                e.tick = (c == len - 1);
                e.done = (c == len - 1) && (k == DATA_BIT - 1);
                exp_q[ch].push_back(e);
            end
        end
    endtask

    task automatic stop_model(input int ch);
`ifdef MCSO_GRACEFUL_STOP_EN
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q[ch].size(); i++)
            if (exp_q[ch][i].done && idx < 0) idx = i;
        if (idx >= 0)
            while (exp_q[ch].size() > idx + 1) void'(exp_q[ch].pop_back());
`else
        exp_q[ch].delete();
`endif
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [CH_NUM-1:0] mask, input logic mode,
                          input logic [DATA_BIT-1:0] out, input logic [DATA_BIT-1:0] freq);
        #1;
        i_cmd_valid = 1'b1;
        i_cmd_op = op;
        i_cmd_mask = mask;
        i_cmd_mode = mode;
        i_output_pattern = out;
        i_freq_pattern = freq;
        @(posedge clk);
        for (int ch = 0; ch < CH_NUM; ch++) begin
            if (mask[ch]) begin
                case (op)
                    2'd0: begin sh_out[ch] = out; sh_freq[ch] = freq; end
                    2'd1: begin exp_q[ch].delete(); push_pat(ch, sh_out[ch], sh_freq[ch]); end
                    2'd2: stop_model(ch);
                    default: ;
                endcase
            end
        end
        #1;
        i_cmd_valid = 1'b0;
        i_cmd_op = 2'd3;
        i_cmd_mask = '0;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 32'(n >= max_cyc), 32'd0);
        repeat (3) @(posedge clk);
    endtask

    // Per-cycle monitor: empty queue means the channel must be idle.
    always @(negedge clk) begin
        if (!rst) begin
            for (int ch = 0; ch < CH_NUM; ch++) begin
                exp_t e;
                exp_t got;
                e = (exp_q[ch].size() != 0) ? exp_q[ch].pop_front() : '0;
                got = {o_busy[ch], o_serial_out[ch], o_bit_tick[ch], o_done_tick[ch]};
                check($sformatf("ch%0d_busy_ser_tick_done", ch), 32'(got), 32'(e));
            end
            busy_cnt += int'(o_busy[0]);
            tick_cnt += int'(o_bit_tick[0]);
            done_cnt += int'(o_done_tick[0]);
        end
    end

    initial begin
        for (int ch = 0; ch < CH_NUM; ch++) begin
            sh_out[ch] = '0;
            sh_freq[ch] = '0;
        end

        #1 rst = 1'b1;
        #2;
        check("reset_outputs", 32'({o_serial_out, o_bit_tick, o_done_tick, o_busy}), 32'd0);
        check("reset_ready", 32'(o_cmd_ready), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1 check("ready_after_reset", 32'(o_cmd_ready), 32'd1);

        // One-shot A5, all fast bits, ch1 untouched
        do_cmd(2'd0, 2'b01, 1'b0, 8'hA5, 8'hFF);
        do_cmd(2'd1, 2'b01, 1'b0, 8'h00, 8'h00);
        drain(60);

        // Mixed rates: four fast then four slow bits
        do_cmd(2'd0, 2'b01, 1'b0, 8'hFF, 8'h0F);
        do_cmd(2'd1, 2'b01, 1'b0, 8'h00, 8'h00);
        busy_cnt = 0;
        tick_cnt = 0;
        done_cnt = 0;
        drain(60);
        check("mixed_busy_cycles", 32'(busy_cnt), 32'd24);
        check("mixed_bit_ticks", 32'(tick_cnt), 32'd8);
        check("mixed_done_ticks", 32'(done_cnt), 32'd1);

        // Both channels started together
        do_cmd(2'd0, 2'b11, 1'b0, 8'h5A, 8'h3C);
        do_cmd(2'd1, 2'b11, 1'b0, 8'h00, 8'h00);
        drain(60);

        // Commands that must change nothing
        do_cmd(2'd1, 2'b00, 1'b0, 8'h00, 8'h00);
        do_cmd(2'd3, 2'b11, 1'b1, 8'hFF, 8'hFF);
        do_cmd(2'd2, 2'b11, 1'b0, 8'h00, 8'h00);
        repeat (4) @(posedge clk);

        // LOAD during a run, then restart picks up the new shadow; STOP to idle ch1
        do_cmd(2'd0, 2'b01, 1'b0, 8'hC3, 8'hFF);
        do_cmd(2'd1, 2'b01, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        do_cmd(2'd0, 2'b01, 1'b0, 8'h3C, 8'hF0);
        repeat (2) @(posedge clk);
        do_cmd(2'd1, 2'b01, 1'b0, 8'h00, 8'h00);
        do_cmd(2'd2, 2'b10, 1'b0, 8'h00, 8'h00);
        drain(80);

        // Repeat mode, LOAD mid-pattern, STOP around bit 3 of the next pattern
        do_cmd(2'd0, 2'b01, 1'b0, 8'h0F, 8'hFF);
        do_cmd(2'd1, 2'b01, 1'b1, 8'h00, 8'h00);
        repeat (4) @(posedge clk);
        do_cmd(2'd0, 2'b01, 1'b0, 8'hF0, 8'hFF);
        push_pat(0, 8'hF0, 8'hFF);
        push_pat(0, 8'hF0, 8'hFF);
        begin
            int n;
            n = 0;
            while (exp_q[0].size() > 26 && n < 200) begin
                @(posedge clk);
                n++;
            end
            check("repeat_wait_timeout", 32'(n >= 200), 32'd0);
        end
        do_cmd(2'd2, 2'b01, 1'b0, 8'h00, 8'h00);
        drain(80);

        // Reset in the middle of a repeat run on both channels
        do_cmd(2'd0, 2'b11, 1'b0, 8'hA5, 8'hFF);
        do_cmd(2'd1, 2'b11, 1'b1, 8'h00, 8'h00);
        push_pat(0, 8'hA5, 8'hFF);
        push_pat(1, 8'hA5, 8'hFF);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun_reset_outputs", 32'({o_serial_out, o_bit_tick, o_done_tick, o_busy}), 32'd0);
        check("midrun_reset_ready", 32'(o_cmd_ready), 32'd0);
        for (int ch = 0; ch < CH_NUM; ch++) begin
            exp_q[ch].delete();
            sh_out[ch] = '0;
            sh_freq[ch] = '0;
        end
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("ready_after_midrun_reset", 32'(o_cmd_ready), 32'd1);
        do_cmd(2'd1, 2'b11, 1'b0, 8'h00, 8'h00);
        drain(80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
